// File: rtl/boolean2_unit.sv
// Evaluates y = (a & b) | (~b & c) combinationally, registers it with its minterm index and counts hits.
// Latency: y_comb_o is combinational; y_o, idx_o, valid_o and ones_cnt_o update 1 cycle after sampling.
// Backpressure: none; a new sample is taken on every clock edge.
module boolean2_unit (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    output logic       y_o,
    output logic       y_comb_o,
    output logic [2:0] idx_o,
    output logic       valid_o,
    output logic [3:0] ones_cnt_o
);

    logic       y_q,     y_d;
    logic [2:0] idx_q,   idx_d;
    logic       valid_q, valid_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       f;

    // Minterms {1,5,6,7} of {a,b,c}
    assign f = (a_i & b_i) | (~b_i & c_i);

    always_comb begin
        y_d     = f;
        idx_d   = {a_i, b_i, c_i};
        valid_d = 1'b1;
        cnt_d   = cnt_q;
        // Saturate at 15 rather than wrapping back to 0
        if (f && (cnt_q != 4'd15)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            y_q     <= 1'b0;
            idx_q   <= 3'b000;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            y_q     <= y_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y_comb_o   = f;
    assign y_o        = y_q;
    assign idx_o      = idx_q;
    assign valid_o    = valid_q;
    assign ones_cnt_o = cnt_q;

endmodule

// File: tb/tb_boolean2_unit.sv
// Randomized and directed stimulus against a truth-table reference model of boolean2_unit.
module tb_boolean2_unit;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       a_i, b_i, c_i;
    logic       y_o, y_comb_o, valid_o;
    logic [2:0] idx_o;
    logic [3:0] ones_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference: truth table indexed by {a,b,c}, values 0,1,0,0,0,1,1,1
    logic [7:0] tt = 8'b1110_0010;
    logic       m_y;
    logic [2:0] m_idx;
    logic       m_valid;
    int         m_cnt;

    boolean2_unit dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .c_i        (c_i),
        .y_o        (y_o),
        .y_comb_o   (y_comb_o),
        .idx_o      (idx_o),
        .valid_o    (valid_o),
        .ones_cnt_o (ones_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".y"},     {31'd0, y_o},        {31'd0, m_y});
        check({tag, ".idx"},   {29'd0, idx_o},      {29'd0, m_idx});
        check({tag, ".valid"}, {31'd0, valid_o},    {31'd0, m_valid});
        check({tag, ".cnt"},   {28'd0, ones_cnt_o}, m_cnt);
    endtask

    // Update the model with what the DUT samples at a rising edge
    task automatic model_edge(input logic r, input logic [2:0] v);
        if (!r) begin
            m_y = 1'b0; m_idx = 3'd0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            m_y = tt[v]; m_idx = v; m_valid = 1'b1;
            if (tt[v] && m_cnt < 15) m_cnt = m_cnt + 1;
        end
    endtask

    // One cycle: drive after the falling edge, check y_comb, take the edge, check registers
    task automatic cycle(input string tag, input logic r, input logic [2:0] v);
        rst_n_i = r;
        {a_i, b_i, c_i} = v;
        #1 check({tag, ".ycomb"}, {31'd0, y_comb_o}, {31'd0, tt[v]});
        @(posedge clk_i);
        model_edge(r, v);
        #1 check_regs(tag);
        @(negedge clk_i);
    endtask

    // Toggle a between edges with b=1,c=0; registered outputs must hold until the edge
    task automatic glitch(input logic final_a);
        rst_n_i = 1'b1;
        b_i = 1'b1; c_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_i = logic'(k[0]);
            #1 check("glitch.ycomb", {31'd0, y_comb_o}, {31'd0, tt[{a_i, 2'b10}]});
            check("glitch.yhold", {31'd0, y_o}, {31'd0, m_y});
        end
        a_i = final_a;
        @(posedge clk_i);
        model_edge(1'b1, {final_a, 2'b10});
        #1 check_regs("glitch");
        @(negedge clk_i);
    endtask

    initial begin
        m_y = 1'b0; m_idx = 3'd0; m_valid = 1'b0; m_cnt = 0;

        // Reset for two cycles, y_comb still live during reset
        cycle("reset", 1'b0, 3'd5);
        cycle("reset", 1'b0, 3'd2);

        // Exhaustive sweep
        for (int i = 0; i < 8; i++) cycle("sweep", 1'b1, 3'(i));

        // Latency: 001 then 000
        cycle("lat1", 1'b1, 3'b001);
        check("lat1.y_is_1", {31'd0, y_o}, 32'd1);
        cycle("lat0", 1'b1, 3'b000);
        check("lat0.y_is_0", {31'd0, y_o}, 32'd0);

        // Saturation from a fresh count
        cycle("satrst", 1'b0, 3'b000);
        for (int i = 1; i <= 20; i++) begin
            cycle("sat", 1'b1, 3'b111);
            if (i == 15) check("sat.at15", {28'd0, ones_cnt_o}, 32'd15);
        end
        check("sat.end", {28'd0, ones_cnt_o}, 32'd15);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle("mid", 1'b1, 3'b101);
        cycle("midrst", 1'b0, 3'b101);
        check("midrst.cnt0", {28'd0, ones_cnt_o}, 32'd0);
        cycle("midrel", 1'b1, 3'b110);
        check("midrel.cnt1", {28'd0, ones_cnt_o}, 32'd1);

        // Inter-edge glitches
        glitch(1'b1);
        glitch(1'b0);
        glitch(1'b1);

        // Reset priority with all inputs high
        cycle("prio", 1'b0, 3'b111);
        cycle("prio", 1'b0, 3'b111);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 19) != 0), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/boolean2_unit.md
BOOLEAN2_UNIT -- requirements
Module: boolean2

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 a  input  1  function input, most significant variable.
REQ-005 b  input  1  function input, middle variable.
REQ-006 c  input  1  function input, least significant variable.
REQ-007 y  output  1  registered result of the Boolean function.
REQ-008 y_comb  output  1  combinational result of the same function, no register.
REQ-009 idx  output  3  registered minterm index {a,b,c} sampled with y.
REQ-010 valid  output  1  high when y and idx hold a result sampled since reset.
REQ-011 ones_cnt  output  4  saturating count of cycles with y_comb=1 since reset.
REQ-012 No parameters; all widths are fixed as listed.

Function
REQ-013 The Boolean function SHALL be y_comb = (a AND b) OR (NOT b AND c), i.e. minterms {1,5,6,7} of index {a,b,c}.
REQ-014 Truth table for idx 0..7: 0,1,0,0,0,1,1,1.
REQ-015 y_comb SHALL follow a, b and c combinationally, with no dependence on clk or rst_n.
REQ-016 On each rising clk edge with rst_n=1, y SHALL load y_comb, and idx SHALL load {a,b,c}; latency is 1 cycle.
REQ-017 valid SHALL go to 1 on the first rising edge with rst_n=1 after reset and stay 1 until the next reset.
REQ-018 On each rising edge with rst_n=1 and y_comb=1, ones_cnt SHALL increment by 1.
REQ-019 ones_cnt SHALL saturate at 15 and never wrap to 0.
REQ-020 Inputs that change between edges SHALL affect only y_comb; registered outputs see only the values sampled at the edge.
REQ-021 X or Z on any input is outside scope; no X-propagation guarantee is required.

Reset
REQ-022 When rst_n=0 at a rising edge: y=0, idx=3'b000, valid=0, ones_cnt=0.
REQ-023 Reset SHALL override any simultaneous sample or count update in the same cycle.
REQ-024 During reset, y_comb SHALL still reflect the current inputs.
REQ-025 Asserting reset in the middle of operation SHALL clear all registered outputs on that edge; the counter restarts from 0.
REQ-026 Before the first clock edge, register values are undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-027 Exhaustive sweep: apply idx 0..7 in order, one per cycle, after reset → y_comb = 0,1,0,0,0,1,1,1 immediately; y/idx show the same values one cycle later.
REQ-028 Latency check: hold {a,b,c}=001 for 1 cycle, then apply 000 → y=1, then y=0 on the following edge; valid=1 throughout after reset release.
REQ-029 Counter saturation: hold {a,b,c}=111 for 20 cycles → ones_cnt reaches 15 at cycle 15 and stays at 15.
REQ-030 Reset mid-operation: after 5 cycles at 101, drive rst_n=0 for 1 edge → y=0, idx=0, valid=0, ones_cnt=0; after release at 110 → y=1, ones_cnt=1 after the next edge.
REQ-031 Inter-edge glitch: toggle a between edges while b=1 and c=0 → y_comb toggles; y changes only at edges, to the value sampled at that edge.
REQ-032 Reset priority: drive rst_n=0 with {a,b,c}=111 → y stays 0 and ones_cnt stays 0 while y_comb=1.
